// File: rtl/main_memory_responder.sv
// Memory-side responder for the L1 D-cache: handshakes a request, then streams an 8-word line or commits one store word.
// Word 0 appears LATENCY+1 edges after address capture; later words wait for the cache's in-order ACK_DATA_L1, and ACK_ADDR stalls.
module main_memory_responder #(
  parameter int    ADDR_BITS      = 10,
  parameter int    WORDS_PER_LINE = 8,
  parameter int    LATENCY        = 2,
  parameter string INIT_FILE      = ""
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VALID,
  input  logic        LOAD,
  input  logic        STORE,
  input  logic        ACK_ADDR,
  input  logic [31:0] DATA_IN,
  input  logic [3:0]  ACK_DATA_L1,
  output logic        READY,
  output logic [31:0] DATA_OUT,
  output logic [3:0]  ACK_DATA_MEM
);

  localparam int DEPTH    = 1 << ADDR_BITS;
  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [OFF_BITS-1:0] LAST_K  = OFF_BITS'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]    LAT_CNT = CNT_W'(LATENCY);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_SEND, S_SDATA, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [OFF_BITS-1:0]  k_q, k_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wr_en;
  logic                 ready_q, ready_d;
  logic [3:0]           ack_q, ack_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          words [DEPTH];
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^DATA_IN[31:ADDR_BITS];

  function automatic logic [31:0] init_word(int idx);
    return 32'(idx);
  endfunction

  // Backing array: power-up image only, deliberately outside the reset domain.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word_q = init_word(i);
    always_ff @(posedge CLK) begin
      if (wr_en && addr_q == ADDR_BITS'(i)) word_q <= DATA_IN;
    end
    assign words[i] = word_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      ack_q   <= 4'hF;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        k_d   = '0;
        cnt_d = '0;
        if (VALID) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (!VALID) state_d = S_IDLE;
        else if (ACK_ADDR) begin
          addr_d = DATA_IN[ADDR_BITS-1:0];
          k_d    = '0;
          cnt_d  = LAT_CNT;
          if (LOAD)       state_d = S_WAIT;
          else if (STORE) state_d = S_SDATA;
          else            state_d = S_DONE;
        end
      end
      // One pass through WAIT even at LATENCY=0 keeps word 0 at LATENCY+1 edges after capture.
      S_WAIT: begin
        if (!VALID)             state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_SEND;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      S_SEND: begin
        if (!VALID) state_d = S_IDLE;
        else if (ACK_DATA_L1 == 4'(k_q) && !ACK_ADDR) begin
          if (k_q == LAST_K) state_d = S_DONE;
          else               k_d     = k_q + 1'b1;
        end
      end
      S_SDATA: begin
        if (!VALID) state_d = S_IDLE;
        else if (ACK_DATA_L1 == 4'h0 && !ACK_ADDR) begin
          wr_en   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!VALID) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in the same edge as the transition.
  always_comb begin
    ready_d = 1'b0;
    ack_d   = 4'hF;
    data_d  = data_q;
    case (state_d)
      S_ADDR, S_WAIT: ready_d = 1'b1;
      S_SEND: begin
        ready_d = 1'b1;
        ack_d   = 4'(k_d);
        data_d  = words[{addr_d[ADDR_BITS-1:OFF_BITS], k_d}];
      end
      S_SDATA: begin
        ready_d = 1'b1;
        ack_d   = 4'h0;
      end
      default: ;
    endcase
  end

  assign READY        = ready_q;
  assign DATA_OUT     = data_q;
  assign ACK_DATA_MEM = ack_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: two instances (LATENCY 2 and 0) share stimulus; a word-array model predicts every line.
module tb_main_memory_responder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        VALID = 1'b0;
  logic        LOAD = 1'b0;
  logic        STORE = 1'b0;
  logic        ACK_ADDR = 1'b0;
  logic [31:0] DATA_IN = 32'h0;
  logic [3:0]  ACK_DATA_L1 = 4'hF;

  logic        ready0, ready1;
  logic [31:0] dout0, dout1;
  logic [3:0]  ack0, ack1;

  logic        use1 = 1'b0;
  logic        obs_ready;
  logic [31:0] obs_dout;
  logic [3:0]  obs_ack;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_mem [1024];

  assign obs_ready = use1 ? ready1 : ready0;
  assign obs_dout  = use1 ? dout1  : dout0;
  assign obs_ack   = use1 ? ack1   : ack0;

  always #5 CLK = ~CLK;

  main_memory_responder #(.ADDR_BITS(10), .WORDS_PER_LINE(8), .LATENCY(2), .INIT_FILE("")) dut_lat2 (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .LOAD(LOAD), .STORE(STORE), .ACK_ADDR(ACK_ADDR),
    .DATA_IN(DATA_IN), .ACK_DATA_L1(ACK_DATA_L1), .READY(ready0), .DATA_OUT(dout0), .ACK_DATA_MEM(ack0)
  );

  main_memory_responder #(.ADDR_BITS(10), .WORDS_PER_LINE(8), .LATENCY(0), .INIT_FILE("")) dut_lat0 (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .LOAD(LOAD), .STORE(STORE), .ACK_ADDR(ACK_ADDR),
    .DATA_IN(DATA_IN), .ACK_DATA_L1(ACK_DATA_L1), .READY(ready1), .DATA_OUT(dout1), .ACK_DATA_MEM(ack1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full load transaction: word k of the line must equal model_mem[base + k].
  task automatic do_load(input logic [31:0] addr, input bit on_lat0, input int delay,
                         input bit stale, input int abort_k, input bit also_store);
    int lat;
    int base;
    logic [9:0] a10;
    lat  = on_lat0 ? 0 : 2;
    use1 = on_lat0;
    a10  = addr[9:0];
    base = int'(a10 & 10'h3F8);
    VALID = 1'b1; LOAD = 1'b1; STORE = also_store; ACK_ADDR = 1'b0;
    DATA_IN = addr; ACK_DATA_L1 = stale ? 4'h7 : 4'hF;
    tick();
    vectors++;
    if (obs_ready !== 1'b1 || obs_ack !== 4'hF) begin
      miscompares++;
      $display("FAIL load_req: ready=%b ack=%h, expected ready=1 ack=f", obs_ready, obs_ack);
    end
    ACK_ADDR = 1'b1;
    tick();
    ACK_ADDR = 1'b0;
    DATA_IN = $urandom();
    vectors++;
    if (obs_ready !== 1'b1 || obs_ack !== 4'hF) begin
      miscompares++;
      $display("FAIL load_capture: ready=%b ack=%h, expected ready=1 ack=f", obs_ready, obs_ack);
    end
    for (int w = 0; w < lat; w++) begin
      tick();
      vectors++;
      if (obs_ready !== 1'b1 || obs_ack !== 4'hF) begin
        miscompares++;
        $display("FAIL load_latency cyc%0d: ready=%b ack=%h, expected ready=1 ack=f", w, obs_ready, obs_ack);
      end
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (obs_ack !== 4'(k) || obs_dout !== model_mem[base + k]) begin
        miscompares++;
        $display("FAIL load_word addr=%h k=%0d: ack=%h data=%h, expected ack=%h data=%h",
                 addr, k, obs_ack, obs_dout, 4'(k), model_mem[base + k]);
      end
      if (k == abort_k) begin
        VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0;
        tick();
        ACK_DATA_L1 = 4'hF;
        vectors++;
        if (obs_ready !== 1'b0 || obs_ack !== 4'hF) begin
          miscompares++;
          $display("FAIL abort: ready=%b ack=%h, expected ready=0 ack=f", obs_ready, obs_ack);
        end
        return;
      end
      for (int d = 0; d < delay; d++) begin
        tick();
        vectors++;
        if (obs_ack !== 4'(k) || obs_dout !== model_mem[base + k]) begin
          miscompares++;
          $display("FAIL load_hold k=%0d: ack=%h data=%h, expected ack=%h data=%h",
                   k, obs_ack, obs_dout, 4'(k), model_mem[base + k]);
        end
      end
      ACK_DATA_L1 = 4'(k);
      tick();
    end
    vectors++;
    if (obs_ready !== 1'b0 || obs_ack !== 4'hF) begin
      miscompares++;
      $display("FAIL load_done: ready=%b ack=%h, expected ready=0 ack=f", obs_ready, obs_ack);
    end
    VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0; ACK_DATA_L1 = 4'hF;
    tick();
    vectors++;
    if (obs_ready !== 1'b0 || obs_ack !== 4'hF) begin
      miscompares++;
      $display("FAIL load_idle: ready=%b ack=%h, expected ready=0 ack=f", obs_ready, obs_ack);
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit reset_mid);
    use1 = 1'b0;
    VALID = 1'b1; STORE = 1'b1; LOAD = 1'b0; ACK_ADDR = 1'b0; DATA_IN = addr; ACK_DATA_L1 = 4'hF;
    tick();
    ACK_ADDR = 1'b1;
    tick();
    vectors++;
    if (obs_ready !== 1'b1 || obs_ack !== 4'h0) begin
      miscompares++;
      $display("FAIL store_sdata: ready=%b ack=%h, expected ready=1 ack=0", obs_ready, obs_ack);
    end
    ACK_ADDR = 1'b0; DATA_IN = data;
    tick();
    vectors++;
    if (obs_ready !== 1'b1 || obs_ack !== 4'h0) begin
      miscompares++;
      $display("FAIL store_wait: ready=%b ack=%h, expected ready=1 ack=0", obs_ready, obs_ack);
    end
    ACK_DATA_L1 = 4'h0;
    if (reset_mid) begin
      #2 RST_N = 1'b0;
      #1;
      vectors++;
      if (ready0 !== 1'b0 || ack0 !== 4'hF || dout0 !== 32'h0) begin
        miscompares++;
        $display("FAIL store_reset: ready=%b ack=%h data=%h, expected 0/f/00000000", ready0, ack0, dout0);
      end
      tick();
      VALID = 1'b0; STORE = 1'b0; ACK_DATA_L1 = 4'hF; RST_N = 1'b1;
      tick();
      return;
    end
    tick();
    model_mem[addr[9:0]] = data;
    vectors++;
    if (obs_ready !== 1'b0 || obs_ack !== 4'hF) begin
      miscompares++;
      $display("FAIL store_done: ready=%b ack=%h, expected ready=0 ack=f", obs_ready, obs_ack);
    end
    VALID = 1'b0; STORE = 1'b0; ACK_DATA_L1 = 4'hF;
    tick();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #1;
    vectors++;
    if (ready0 !== 1'b0 || dout0 !== 32'h0 || ack0 !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_lat2: ready=%b data=%h ack=%h, expected 0/00000000/f", ready0, dout0, ack0);
    end
    vectors++;
    if (ready1 !== 1'b0 || dout1 !== 32'h0 || ack1 !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_lat0: ready=%b data=%h ack=%h, expected 0/00000000/f", ready1, dout1, ack1);
    end
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_load();
    do_load(32'h0000_0013, 1'b0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_store_then_load();
    do_store(32'h0000_0025, 32'hDEAD_BEEF, 1'b0);
    do_load(32'h0000_0020, 1'b0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_slow_cache();
    do_load(32'h0000_0140, 1'b0, 3, 1'b1, -1, 1'b0);
    do_load(32'h0000_0077, 1'b1, 3, 1'b1, -1, 1'b0);
  endtask

  task automatic test_abort();
    do_load(32'h0000_0031, 1'b0, 0, 1'b0, 3, 1'b0);
    do_load(32'h0000_0031, 1'b0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_store();
    do_store(32'h0000_0052, 32'hCAFE_F00D, 1'b1);
    do_load(32'h0000_0050, 1'b0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_alias_latency0();
    do_load(32'hFFFF_FC08, 1'b1, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_store($urandom(), $urandom(), 1'b0);
      end else begin
        do_load($urandom(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1,
                1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'(i);
    #2;
    test_reset();
    test_load();
    test_store_then_load();
    test_slow_cache();
    test_abort();
    test_reset_mid_store();
    test_alias_latency0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
